// File: rtl/ring_buffer_frame_pkg.sv
// -----------------------------------------------------------------------------
// ring_buffer_frame_pkg
//
// Shared definitions for the ring_buffer_frame slice.
//   RBF_DATA_W  : default sample width in bits
//   RBF_ADDR_W  : default address width of the sample store
//   RBF_DEPTH   : default number of slots (2**RBF_ADDR_W)
//   rbf_state_t : readout controller state (IDLE, READ)
// -----------------------------------------------------------------------------
package ring_buffer_frame_pkg;

   localparam int RBF_DATA_W = 10;
   localparam int RBF_ADDR_W = 8;
   localparam int RBF_DEPTH  = 1 << RBF_ADDR_W;

   // IDLE : waiting for a Send_Frame rising edge
   // READ : issuing one slot read per cycle, oldest slot first
   typedef enum logic {
      IDLE = 1'b0,
      READ = 1'b1
   } rbf_state_t;

endpackage : ring_buffer_frame_pkg

// File: rtl/ring_buffer_frame_dpram.sv
// -----------------------------------------------------------------------------
// rbf_dpram
//
// Simple dual-port RAM: one write port, one registered read port, one cycle
// of read latency. Written in the plain form synthesis tools map onto block
// RAM, so the array carries no reset.
//
// A read and a write to the same address on the same edge return the data
// held before the write (read-before-write): both updates are non-blocking,
// so rd_data samples the old array contents.
//
// Ports
//   clk      in   clock, rising edge
//   wr_en    in   write strobe
//   wr_addr  in   ADDR_W  write address
//   wr_data  in   DATA_W  write data
//   rd_addr  in   ADDR_W  read address, sampled every cycle
//   rd_data  out  DATA_W  registered read data
// -----------------------------------------------------------------------------
module rbf_dpram
   import ring_buffer_frame_pkg::*;
#(
   parameter int DATA_W = RBF_DATA_W,
   parameter int ADDR_W = RBF_ADDR_W
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem [0:DEPTH-1];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      rd_data <= mem[rd_addr];
   end

endmodule : rbf_dpram

// File: rtl/ring_buffer_frame.sv
// -----------------------------------------------------------------------------
// ring_buffer_frame
//
// Captures samples from an SPI front end into a circular buffer of DEPTH
// slots and, on request, streams the most recent DEPTH samples out in
// arrival order (oldest first).
//
// Write side: one sample is stored per rising edge of Input_Data_Ready,
// however long the pulse stays high. The write pointer wraps modulo DEPTH
// and a saturating fill counter remembers how many slots hold real data.
//
// Read side: a Send_Frame rising edge seen in IDLE at cycle T latches
// base = write pointer (after any write on that same edge). Slot base+k is
// presented on Output_Data at cycle T+2+k, k = 0..DEPTH-1. Slots never
// written since reset are shown as 0, and Output_Data is 0 outside readout.
// Send_Frame edges during readout are ignored. Writes keep going during
// readout.
//
// Optional feature, macro RING_BUFFER_OVERFLOW_DETECT_EN:
//   defined   - RAM_Overflow is a sticky flag (cleared only by reset) that
//               rises when a write lands on a frame slot whose read has not
//               yet been issued by the current readout. The slot being read
//               on that very edge counts as not yet read: its read returns
//               the old data, so the new sample misses this frame.
//   undefined - RAM_Overflow is tied to 0 and no tracking logic exists.
//
// Ports
//   clk               in   clock, all logic on rising edge
//   reset_b           in   synchronous active-low reset
//   Input_Data        in   DATA_W  sample, stable while Input_Data_Ready high
//   Input_Data_Ready  in   level pulse marking a new sample
//   Send_Frame        in   request to stream the latest DEPTH samples
//   RAM_Overflow      out  sticky overwrite flag (see above)
//   Output_Data       out  DATA_W  registered frame sample stream
// -----------------------------------------------------------------------------
module ring_buffer_frame
   import ring_buffer_frame_pkg::*;
#(
   parameter int DATA_W = RBF_DATA_W,
   parameter int ADDR_W = RBF_ADDR_W
) (
   input  logic              clk,
   input  logic              reset_b,
   input  logic [DATA_W-1:0] Input_Data,
   input  logic              Input_Data_Ready,
   input  logic              Send_Frame,
   output logic              RAM_Overflow,
   output logic [DATA_W-1:0] Output_Data
);

   localparam int                DEPTH  = 1 << ADDR_W;
   localparam logic [ADDR_W:0]   FULL   = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_K = '1;

   // ---------------------------------------------------------------------
   // Edge detection
   // ---------------------------------------------------------------------
   logic dr_q;
   logic sf_q;
   logic wr_en;
   logic sf_edge;

   assign wr_en   = Input_Data_Ready & ~dr_q;
   assign sf_edge = Send_Frame & ~sf_q;

   always_ff @(posedge clk) begin
      if (!reset_b) begin
         dr_q <= 1'b0;
         sf_q <= 1'b0;
      end else begin
         dr_q <= Input_Data_Ready;
         sf_q <= Send_Frame;
      end
   end

   // ---------------------------------------------------------------------
   // Write pointer and saturating fill count
   // ---------------------------------------------------------------------
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] wr_ptr_nxt;
   logic [ADDR_W:0]   fill_cnt;
   logic              fill_full;

   assign wr_ptr_nxt = wr_ptr + 1'b1;
   assign fill_full  = (fill_cnt == FULL);

   always_ff @(posedge clk) begin
      if (!reset_b) begin
         wr_ptr   <= '0;
         fill_cnt <= '0;
      end else if (wr_en) begin
         wr_ptr <= wr_ptr_nxt;
         if (!fill_full) begin
            fill_cnt <= fill_cnt + 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Readout controller
   // ---------------------------------------------------------------------
   rbf_state_t        state;
   logic [ADDR_W-1:0] base;
   logic [ADDR_W-1:0] rd_k;
   logic [ADDR_W-1:0] rd_addr;
   logic              slot_valid;
   logic              rd_vld_q;

   assign rd_addr = base + rd_k;

   // Until the buffer has wrapped, the written slots are exactly
   // 0..fill_cnt-1 (wr_ptr equals fill_cnt). The registered fill count is
   // the pre-write value, which matches the read-before-write RAM data.
   assign slot_valid = fill_full | ({1'b0, rd_addr} < fill_cnt);

   always_ff @(posedge clk) begin
      if (!reset_b) begin
         state    <= IDLE;
         base     <= '0;
         rd_k     <= '0;
         rd_vld_q <= 1'b0;
      end else begin
         rd_vld_q <= 1'b0;
         case (state)
            IDLE: begin
               if (sf_edge) begin
                  // A write on this same edge belongs to the frame as its
                  // newest sample, so the oldest slot is one further on.
                  base  <= wr_en ? wr_ptr_nxt : wr_ptr;
                  rd_k  <= '0;
                  state <= READ;
               end
            end
            READ: begin
               rd_vld_q <= slot_valid;
               rd_k     <= rd_k + 1'b1;
               if (rd_k == LAST_K) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Sample store
   // ---------------------------------------------------------------------
   logic [DATA_W-1:0] ram_q;

   rbf_dpram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_dpram (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr),
      .wr_data (Input_Data),
      .rd_addr (rd_addr),
      .rd_data (ram_q)
   );

   // ---------------------------------------------------------------------
   // Output register: zero outside readout and for never-written slots
   // ---------------------------------------------------------------------
   logic [DATA_W-1:0] out_q;

   always_ff @(posedge clk) begin
      if (!reset_b) begin
         out_q <= '0;
      end else begin
         out_q <= rd_vld_q ? ram_q : '0;
      end
   end

   assign Output_Data = out_q;

   // ---------------------------------------------------------------------
   // Overflow tracking
   // ---------------------------------------------------------------------
`ifdef RING_BUFFER_OVERFLOW_DETECT_EN
   logic [ADDR_W-1:0] wr_off;
   logic              ovf_q;

   // Position of the write inside the current frame; slots at or beyond
   // the one being read now have not been delivered by this readout yet.
   assign wr_off = wr_ptr - base;

   always_ff @(posedge clk) begin
      if (!reset_b) begin
         ovf_q <= 1'b0;
      end else if ((state == READ) && wr_en && (wr_off >= rd_k)) begin
         ovf_q <= 1'b1;
      end
   end

   assign RAM_Overflow = ovf_q;
`else
   assign RAM_Overflow = 1'b0;
`endif

endmodule : ring_buffer_frame

// File: tb/tb_ring_buffer_frame.sv
// -----------------------------------------------------------------------------
// tb_ring_buffer_frame
//
// Self-checking bench for ring_buffer_frame. Inputs change 1 ns after the
// rising edge; outputs are sampled at that same point, one edge after they
// were registered. A reference history of accepted samples builds each
// expected frame, which is queued when Send_Frame is driven and popped as the
// frame streams out.
// -----------------------------------------------------------------------------
module tb_ring_buffer_frame;

   localparam int DATA_W = 10;
   localparam int ADDR_W = 8;
   localparam int DEPTH  = 1 << ADDR_W;

   // ------------------------------------------------------------------
   // Clock / reset
   // ------------------------------------------------------------------
   logic              clk;
   logic              reset_b;
   logic [DATA_W-1:0] Input_Data;
   logic              Input_Data_Ready;
   logic              Send_Frame;
   logic              RAM_Overflow;
   logic [DATA_W-1:0] Output_Data;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   ring_buffer_frame #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) dut (
      .clk              (clk),
      .reset_b          (reset_b),
      .Input_Data       (Input_Data),
      .Input_Data_Ready (Input_Data_Ready),
      .Send_Frame       (Send_Frame),
      .RAM_Overflow     (RAM_Overflow),
      .Output_Data      (Output_Data)
   );

   // ------------------------------------------------------------------
   // Scoreboard state
   // ------------------------------------------------------------------
   logic [DATA_W-1:0] exp_q[$];
   logic [DATA_W-1:0] hist[$];
   int                frame_wait;
   int                n_cmp;
   int                n_err;
   logic              exp_ovf;

   task automatic check_val(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   // Expected frame: last DEPTH accepted samples, zero-padded in front.
   task automatic push_frame();
      int n;
      int idx;
      n = hist.size();
      for (int k = 0; k < DEPTH; k++) begin
         idx = n - DEPTH + k;
         if (idx < 0) exp_q.push_back('0);
         else         exp_q.push_back(hist[idx]);
      end
   endtask

   // One clock; then compare Output_Data against the scoreboard.
   task automatic step();
      @(posedge clk);
      #1;
      if (frame_wait > 0) begin
         frame_wait--;
      end else if (exp_q.size() > 0) begin
         check_val("frame_data", 32'(Output_Data), 32'(exp_q.pop_front()));
      end else begin
         check_val("idle_zero", 32'(Output_Data), 32'd0);
      end
   endtask

   // ------------------------------------------------------------------
   // Driver tasks
   // ------------------------------------------------------------------
   task automatic write_sample(input logic [DATA_W-1:0] val, input int hi,
                               input int lo);
      Input_Data       = val;
      Input_Data_Ready = 1'b1;
      repeat (hi) step();
      Input_Data_Ready = 1'b0;
      repeat (lo) step();
      hist.push_back(val);
   endtask

   // Raise Send_Frame (optionally with a write on the same edge), stream
   // the whole frame, keep Send_Frame high 'hold' extra cycles afterwards.
   task automatic send_frame(input bit with_wr, input logic [DATA_W-1:0] wval,
                             input int hold);
      if (with_wr) begin
         Input_Data       = wval;
         Input_Data_Ready = 1'b1;
         hist.push_back(wval);
      end
      Send_Frame = 1'b1;
      push_frame();
      frame_wait = 2;
      step();                       // edge T
      Input_Data_Ready = 1'b0;
      if (hold == 0) Send_Frame = 1'b0;
      repeat (DEPTH + 1) step();    // T+1 .. T+DEPTH+1
      repeat (hold) step();
      Send_Frame = 1'b0;
      repeat (3) step();
   endtask

   // ------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------
   initial begin
      n_cmp            = 0;
      n_err            = 0;
      frame_wait       = 0;
      reset_b          = 1'b0;
      Input_Data       = '0;
      Input_Data_Ready = 1'b0;
      Send_Frame       = 1'b0;
`ifdef RING_BUFFER_OVERFLOW_DETECT_EN
      exp_ovf = 1'b1;
`else
      exp_ovf = 1'b0;
`endif

      // Reset state
      repeat (3) step();
      check_val("rst_ovf", 32'(RAM_Overflow), 32'd0);
      reset_b = 1'b1;
      step();

      // Ten long pulses; frame is 246 zeros then 1..10
      for (int i = 1; i <= 10; i++) write_sample(DATA_W'(i), 14, 182);
      send_frame(1'b0, '0, 0);
      check_val("t1_ovf", 32'(RAM_Overflow), 32'd0);

      // 300 samples valued by index; frame carries 44..299
      for (int i = 0; i < 300; i++) write_sample(DATA_W'(i), 1, 1);
      send_frame(1'b0, '0, 0);

      // Write on the Send_Frame edge is the newest sample; Send_Frame held
      // high well past the readout must not start another frame
      send_frame(1'b1, 10'h3a5, 20);
      check_val("t3_ovf", 32'(RAM_Overflow), 32'd0);

      // Full buffer, frame, writes every 2 cycles from T+1
      Send_Frame = 1'b1;
      push_frame();
      frame_wait = 2;
      step();                       // edge T
      Send_Frame = 1'b0;
      check_val("t4_ovf_pre", 32'(RAM_Overflow), 32'd0);
      for (int j = 0; j < DEPTH / 2; j++) begin
         Input_Data       = DATA_W'(500 + j);
         Input_Data_Ready = 1'b1;
         step();
         Input_Data_Ready = 1'b0;
         step();
         hist.push_back(DATA_W'(500 + j));
      end
      repeat (3) step();
      check_val("t4_ovf_end", 32'(RAM_Overflow), 32'(exp_ovf));
      repeat (10) step();
      check_val("t4_ovf_sticky", 32'(RAM_Overflow), 32'(exp_ovf));

      // Re-pulse at T+50 ignored, reset at T+100 aborts readout
      Send_Frame = 1'b1;
      push_frame();
      frame_wait = 2;
      step();                       // edge T
      for (int c = 1; c < 100; c++) begin
         Send_Frame = (c == 50);
         step();
      end
      reset_b = 1'b0;
      exp_q.delete();
      frame_wait = 0;
      hist.delete();
      step();                       // edge T+100: Output_Data must be 0
      check_val("t5_rst_ovf", 32'(RAM_Overflow), 32'd0);
      reset_b = 1'b1;
      step();
      send_frame(1'b0, '0, 0);      // fill count 0: all zeros
      check_val("t5_ovf_end", 32'(RAM_Overflow), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_ring_buffer_frame

// File: doc/ring_buffer_frame.md
RING_BUFFER_FRAME -- requirements
Module: ring_buffer_frame

Interface
REQ-001 Parameter DATA_W, default 10, sample width in bits.
REQ-002 Parameter ADDR_W, default 8, address width; depth DEPTH = 2**ADDR_W (256).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset_b  input  1  synchronous active-low reset.
REQ-005 Input_Data  input  DATA_W  sample from SPI front end; stable while Input_Data_Ready is high.
REQ-006 Input_Data_Ready  input  1  level pulse (multi-cycle) marking a new sample.
REQ-007 Send_Frame  input  1  request to stream the latest DEPTH samples.
REQ-008 RAM_Overflow  output  1  sticky flag: an unread frame slot was overwritten.
REQ-009 Output_Data  output  DATA_W  registered frame sample stream.

Function
REQ-010 The block SHALL detect Input_Data_Ready rising edges (high now, low last cycle) and write exactly one sample per edge, regardless of pulse length.
REQ-011 Each write SHALL store Input_Data at wr_ptr, then increment wr_ptr modulo DEPTH (255 wraps to 0).
REQ-012 The block SHALL count writes since reset, saturating at DEPTH.
REQ-013 A Send_Frame rising edge at cycle T while idle SHALL snapshot base = wr_ptr (after any same-cycle write) and start readout.
REQ-014 Readout SHALL present slot base+k (mod DEPTH), k = 0..DEPTH-1, on Output_Data at cycle T+2+k: oldest first, newest at T+DEPTH+1.
REQ-015 Slots never written since reset SHALL read as 0.
REQ-016 Outside readout, Output_Data SHALL be 0.
REQ-017 Send_Frame edges during readout SHALL be ignored; a held-high Send_Frame SHALL not retrigger.
REQ-018 Writes SHALL continue during readout.
REQ-019 A write to a slot not yet read in the current readout SHALL set RAM_Overflow; the frame then carries the new value for that slot.
REQ-020 RAM_Overflow SHALL clear only on reset.
REQ-021 A write and a read of the same address in one cycle SHALL return the old data (read-before-write).

Reset
REQ-022 While reset_b is low: wr_ptr = 0, fill count = 0, readout aborted, edge-detect history = 0, Output_Data = 0, RAM_Overflow = 0.
REQ-023 RAM contents SHALL NOT be reset; REQ-015 masks stale data.
REQ-024 Reset asserted mid-readout SHALL abort it; Output_Data SHALL be 0 on the next cycle.

Configuration
REQ-025 With RING_BUFFER_OVERFLOW_DETECT_EN defined, RAM_Overflow SHALL behave per REQ-019/020.
REQ-026 Without it, RAM_Overflow SHALL be tied to 0 and no overflow tracking logic SHALL be synthesized; all other behaviour is unchanged.

Structure
REQ-027 A shared package SHALL hold DATA_W, ADDR_W and DEPTH defaults and the readout state enum (IDLE, READ).
REQ-028 Storage SHALL be one sub-module, rbf_dpram: simple dual-port RAM, 1 write port and 1 registered read port, 1-cycle read latency, inferable as block RAM.
REQ-029 Control SHALL use two states: IDLE -> READ on an accepted Send_Frame edge; READ -> IDLE after k = DEPTH-1 is issued, or on reset.

Verification
REQ-030 Bench SHALL cover reset -> Output_Data = 0 and RAM_Overflow = 0; write 10 samples 1..10 as 14-cycle pulses every 196 cycles, Send_Frame -> 246 zeros, then 1..10; each sample written once.
REQ-031 Bench SHALL cover writing 300 samples with values = index, then Send_Frame -> values 44..299 in order, first at T+2, last at T+257.
REQ-032 Bench SHALL cover a write in the same cycle as the Send_Frame edge -> that sample is last in the frame.
REQ-033 Bench SHALL cover a full buffer, Send_Frame, then writes every 2 cycles during readout -> RAM_Overflow = 1 and stays 1 after readout; with the macro undefined -> stays 0.
REQ-034 Bench SHALL cover a Send_Frame re-pulse at T+50 -> ignored; reset at T+100 -> Output_Data = 0 next cycle, and a new Send_Frame then yields all zeros (fill count 0).
